// File: rtl/mat_addr_buf.sv
// Feature-point address buffer: collects up to DEPTH addresses, then holds a flat snapshot until acknowledged.
// Writes land 1 cycle after wr_en; snapshot appears 1 cycle after rd_req; writes during HOLD or when full are dropped (sticky overflow).
module mat_addr_buf #(
    parameter int AW        = 15,
    parameter int DEPTH     = 16,
    parameter int MIN_MATCH = 4,
    parameter int DEDUP     = 1,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_data,
    input  logic                  rd_req,
    input  logic                  rd_ack,
    output logic [DEPTH*AW-1:0]   position,
    output logic [DEPTH-1:0]      slot_valid,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  out_valid,
    output logic                  is_matching,
    output logic                  overflow
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [AW-1:0]     r_slot [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic [AW-1:0]     w_last;
    logic              w_dup;
    logic              w_store;
    logic [CW-1:0]     w_wr_idx;
    logic              w_clear;
    logic              w_ovf_set;
    logic              w_ovf_clr;

    // Most recently stored address; count doubles as the write pointer.
    always_comb begin
        w_last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == r_count) begin
                w_last = r_slot[i];
            end
        end
    end

    assign w_dup = (DEDUP != 0) && (r_count != '0) && (wr_data == w_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_wr_idx    = r_count;
        w_clear     = 1'b0;
        w_ovf_set   = 1'b0;
        w_ovf_clr   = 1'b0;
        if (frame_start) begin
            // New frame wins; a same-cycle write becomes slot 0 without dedup.
            w_state_nxt = ST_COLLECT;
            w_clear     = 1'b1;
            w_ovf_clr   = 1'b1;
            w_wr_idx    = '0;
            w_store     = wr_en;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (wr_en) begin
                        if (r_count == CW'(DEPTH)) begin
                            w_ovf_set = 1'b1;
                        end else if (!w_dup) begin
                            w_store = 1'b1;
                        end
                    end
                    if (rd_req) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    w_ovf_set = wr_en;
                    if (rd_ack) begin
                        w_state_nxt = ST_COLLECT;
                        w_clear     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
            r_valid    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_slot[i] <= '0;
                end
                r_valid <= '0;
                r_count <= '0;
            end
            if (w_store) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == w_wr_idx) begin
                        r_slot[i]  <= wr_data;
                        r_valid[i] <= 1'b1;
                    end
                end
                r_count <= w_wr_idx + CW'(1);
            end
            if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Slot 0 occupies the most significant lane of both flat outputs.
    always_comb begin
        position   = '0;
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            position[(DEPTH - i) * AW - 1 -: AW] = r_slot[i];
            slot_valid[DEPTH - 1 - i]            = r_valid[i];
        end
    end

    assign count       = r_count;
    assign full        = (r_count == CW'(DEPTH));
    assign out_valid   = (r_state == ST_HOLD);
    assign is_matching = out_valid && (r_count >= CW'(MIN_MATCH));
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_mat_addr_buf.sv
// Directed bench for mat_addr_buf with default parameters (AW=15, DEPTH=16, MIN_MATCH=4, DEDUP=1).
module tb_mat_addr_buf;

    localparam int AW    = 15;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 clk;
    logic                 rst;
    logic                 frame_start;
    logic                 wr_en;
    logic [AW-1:0]        wr_data;
    logic                 rd_req;
    logic                 rd_ack;
    logic [DEPTH*AW-1:0]  position;
    logic [DEPTH-1:0]     slot_valid;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 out_valid;
    logic                 is_matching;
    logic                 overflow;

    int checks;
    int failures;

    mat_addr_buf #(
        .AW(AW), .DEPTH(DEPTH), .MIN_MATCH(4), .DEDUP(1)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req), .rd_ack(rd_ack),
        .position(position), .slot_valid(slot_valid), .count(count),
        .full(full), .out_valid(out_valid), .is_matching(is_matching),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] slot(input int i);
        return position[(DEPTH - i) * AW - 1 -: AW];
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic req();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    logic [DEPTH*AW-1:0] exp_pos;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_data = '0;
        rd_req = 1'b0; rd_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_slot_valid", 256'(slot_valid), 256'(0));
        chk("rst_position", 256'(position), 256'(0));
        chk("rst_full_ovf", 256'({full, overflow, is_matching}), 256'(0));

        // Three writes then snapshot
        wr(15'h0001); wr(15'h0002); wr(15'h0003);
        req();
        exp_pos = {15'h0001, 15'h0002, 15'h0003, {13{15'h0000}}};
        chk("t1_out_valid", 256'(out_valid), 256'(1));
        chk("t1_count", 256'(count), 256'(3));
        chk("t1_is_matching", 256'(is_matching), 256'(0));
        chk("t1_slot_valid", 256'(slot_valid), 256'(16'hE000));
        chk("t1_position", 256'(position), 256'(exp_pos));

        // Release snapshot
        ack();
        chk("ack_out_valid", 256'(out_valid), 256'(0));
        chk("ack_count", 256'(count), 256'(0));
        chk("ack_slot_valid", 256'(slot_valid), 256'(0));
        chk("ack_position", 256'(position), 256'(0));
        chk("ack_overflow", 256'(overflow), 256'(0));

        // rd_ack while collecting is ignored
        wr(15'h0042);
        ack();
        chk("ack_collect_count", 256'(count), 256'(1));
        fs();
        chk("fs_clear_count", 256'(count), 256'(0));

        // Fill all slots, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            wr(15'(16'h0100 + i));
            if (i == DEPTH - 2) chk("full_before_last", 256'(full), 256'(0));
        end
        chk("full_at_16", 256'(full), 256'(1));
        chk("no_ovf_at_16", 256'(overflow), 256'(0));
        wr(15'h7FFF);
        chk("ovf_full", 256'(full), 256'(1));
        chk("ovf_count", 256'(count), 256'(16));
        chk("ovf_flag", 256'(overflow), 256'(1));
        chk("ovf_slot15", 256'(slot(15)), 256'(15'h010F));
        chk("ovf_slot0", 256'(slot(0)), 256'(15'h0100));
        req();
        chk("full_is_matching", 256'(is_matching), 256'(1));
        ack();
        chk("ovf_retained", 256'(overflow), 256'(1));
        chk("ack2_count", 256'(count), 256'(0));
        fs();
        chk("fs_clears_ovf", 256'(overflow), 256'(0));

        // Duplicate suppression only against the latest stored entry
        wr(15'h0010); wr(15'h0010); wr(15'h0011); wr(15'h0010);
        chk("dedup_count", 256'(count), 256'(3));
        chk("dedup_slots", 256'({slot(0), slot(1), slot(2)}), 256'({15'h0010, 15'h0011, 15'h0010}));
        chk("dedup_ovf", 256'(overflow), 256'(0));

        // Same-cycle write and request: write lands in the snapshot
        wr_en = 1'b1; wr_data = 15'h0ABC; rd_req = 1'b1;
        tick();
        wr_en = 1'b0; rd_req = 1'b0;
        chk("wr_req_out_valid", 256'(out_valid), 256'(1));
        chk("wr_req_count", 256'(count), 256'(4));
        chk("wr_req_slot3", 256'(slot(3)), 256'(15'h0ABC));
        chk("wr_req_is_matching", 256'(is_matching), 256'(1));
        wr(15'h0555);
        req();
        chk("hold_ovf", 256'(overflow), 256'(1));
        chk("hold_count", 256'(count), 256'(4));
        chk("hold_slot4", 256'(slot(4)), 256'(0));
        chk("hold_slot_valid", 256'(slot_valid), 256'(16'hF000));
        chk("hold_still_valid", 256'(out_valid), 256'(1));
        ack();
        fs();

        // frame_start with write while holding 5 entries
        for (int i = 1; i <= 5; i++) wr(15'(i));
        req();
        chk("hold5_count", 256'(count), 256'(5));
        frame_start = 1'b1; wr_en = 1'b1; wr_data = 15'h1234;
        tick();
        frame_start = 1'b0; wr_en = 1'b0;
        chk("fs_wr_out_valid", 256'(out_valid), 256'(0));
        chk("fs_wr_count", 256'(count), 256'(1));
        chk("fs_wr_slot0", 256'(slot(0)), 256'(15'h1234));
        chk("fs_wr_slot_valid", 256'(slot_valid), 256'(16'h8000));
        wr(15'h1234);
        chk("fs_then_dup_count", 256'(count), 256'(1));

        // Asynchronous reset in the middle of HOLD
        wr(15'h0002); wr(15'h0003); wr(15'h0004);
        req();
        chk("pre_rst_is_matching", 256'(is_matching), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 256'(out_valid), 256'(0));
        chk("arst_is_matching", 256'(is_matching), 256'(0));
        chk("arst_count", 256'(count), 256'(0));
        chk("arst_position", 256'(position), 256'(0));
        chk("arst_slot_valid", 256'(slot_valid), 256'(0));
        tick();
        rst = 1'b0;
        tick();
        wr(15'h0077);
        chk("post_rst_collect", 256'({out_valid, count}), 256'({1'b0, 5'd1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_addr_buf.md
# mat_addr_buf

Parametrised, clocked feature-point address buffer for the matching stage. It collects up to DEPTH feature-point addresses per frame into slots using an auto-incrementing write pointer, with optional duplicate suppression. On request it freezes a snapshot and presents all slots as one flat bus, together with a per-slot valid mask and a match verdict. It holds that snapshot until the downstream matcher acknowledges it, then clears for the next collection.

## Interface
Parameters:
- AW, 15: width of one feature-point address.
- DEPTH, 16: number of slots (≥2).
- MIN_MATCH, 4: minimum stored count for is_matching (1..DEPTH).
- DEDUP, 1: 1 = drop a write equal to the most recently stored address; 0 = store every write.
- CW, $clog2(DEPTH+1): width of count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  synchronous clear of all slots, count and overflow; returns to COLLECT.
- wr_en  in  1  write strobe for wr_data.
- wr_data  in  AW  feature-point address to store.
- rd_req  in  1  request snapshot.
- rd_ack  in  1  consumer has taken the snapshot.
- position  out  DEPTH*AW  slot 0 in bits [DEPTH*AW-1 -: AW], slot DEPTH-1 in bits [AW-1:0]; unwritten slots read 0.
- slot_valid  out  DEPTH  bit i = slot i written; bit DEPTH-1 = slot 0 (same order as position).
- count  out  CW  number of stored slots, 0..DEPTH.
- full  out  1  count == DEPTH.
- out_valid  out  1  snapshot presented (state HOLD).
- is_matching  out  1  out_valid && count ≥ MIN_MATCH.
- overflow  out  1  sticky: a write was dropped for lack of space or because state was HOLD.

## Operation
- States: COLLECT, HOLD. Reset state is COLLECT.
- Reset values: all slots 0, slot_valid 0, count 0, full 0, out_valid 0, is_matching 0, overflow 0.
- COLLECT write handling:
  - wr_en with count < DEPTH stores wr_data in slot[count], sets its valid bit and increments count.
  - Exception: when DEDUP=1, count > 0 and wr_data == slot[count-1], the write is dropped silently. count and overflow are unchanged.
  - wr_en with count == DEPTH drops the write and sets overflow.
- COLLECT -> HOLD on rd_req.
  - A wr_en in the same cycle is processed first and is included in the snapshot.
- HOLD behaviour:
  - Slots, count and slot_valid are frozen.
  - wr_en drops the write and sets overflow.
  - rd_req is ignored.
- HOLD -> COLLECT on rd_ack. Clears slots, slot_valid and count. overflow is kept until frame_start or rst.
- rd_ack in COLLECT is ignored.
- frame_start has priority over everything, in either state:
  - Clears slots, slot_valid, count and overflow, and goes to COLLECT.
  - Same-cycle rd_req and rd_ack are ignored.
  - A same-cycle wr_en is stored as slot 0 of the new frame (count = 1 afterwards). Dedup does not apply to this write.
- Arithmetic: count saturates at DEPTH and never wraps. The write pointer is count itself; no separate pointer.

## Timing
- All outputs are registered, or are combinational from registered state only. There are no input-to-output combinational paths.
- Write latency is 1 cycle: data, slot_valid and count update on the edge that samples wr_en.
- full asserts in the cycle after the DEPTH-th accepted write.
- out_valid and is_matching rise 1 cycle after the rd_req edge. They fall 1 cycle after the rd_ack edge or the frame_start edge.
- Minimum snapshot handshake is 2 cycles: rd_req, then rd_ack in the next cycle. A new rd_req is accepted in the cycle after out_valid falls.
- rst asserted mid-HOLD forces all outputs to 0 immediately (asynchronous). On deassertion the block is in COLLECT.

## Test plan
- Reset, then write 0x0001, 0x0002, 0x0003, then rd_req. Required on the next cycle:
  - out_valid=1, count=3, is_matching=0.
  - slot_valid=16'hE000.
  - position top three slots are 0x0001, 0x0002, 0x0003; all other slots are 0.
- 16 distinct writes followed by a 17th write (0x7FFF). Required: full=1, count=16, overflow=1, and slot 15 ≠ 0x7FFF. Then rd_req gives is_matching=1.
- DEDUP=1, writes 0x0010, 0x0010, 0x0011, 0x0010. Required: count=3, slots hold 0x0010, 0x0011, 0x0010, overflow=0.
- Same-cycle wr_en(0x0ABC) and rd_req with count=3. Required: snapshot count=4 and slot 3 = 0x0ABC. A write during HOLD sets overflow, and the snapshot is unchanged.
- HOLD, then rd_ack. Required on the next cycle: out_valid=0, count=0, slot_valid=0, position=0, overflow retained. A subsequent frame_start clears overflow.
- frame_start with wr_en(0x1234) while in HOLD holding 5 entries. Required: next cycle state COLLECT, count=1, slot 0 = 0x1234, out_valid=0. Also: rst pulsed mid-HOLD gives all outputs 0 asynchronously.
